// File: rtl/blitter_pkg.sv
// rtl/blitter_pkg.sv - shared mode encodings, FSM states and screen defaults for sprite_blitter
package blitter_pkg;

  // Draw command encodings; the reserved code 3 is decoded as a clear
  localparam logic [1:0] MODE_SPRITE = 2'd0;
  localparam logic [1:0] MODE_FILL   = 2'd1;
  localparam logic [1:0] MODE_CLEAR  = 2'd2;

  // Default screen geometry and pixel format for the vga_adapter target
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int COLOUR_W_DEF = 15;

  // Command sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Both CLEAR and the reserved encoding scan the whole screen
  function automatic logic mode_is_clear(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Only SPRITE mode takes its colour from the sprite ROM
  function automatic logic mode_is_sprite(input logic [1:0] mode);
    return mode == MODE_SPRITE;
  endfunction

endpackage

// File: rtl/blit_scan_counter.sv
// rtl/blit_scan_counter.sv - raster (cx,cy) counter with programmable extent and last-coordinate flag
module blit_scan_counter #(
  parameter int X_W = 9,
  parameter int Y_W = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           clear_i,
  input  logic           en_i,
  input  logic [X_W-1:0] w_max_i,
  input  logic [Y_W-1:0] h_max_i,
  output logic [X_W-1:0] cx_o,
  output logic [Y_W-1:0] cy_o,
  output logic           last_o
);

  logic [X_W-1:0] cx_q;
  logic [X_W-1:0] cx_d;
  logic [Y_W-1:0] cy_q;
  logic [Y_W-1:0] cy_d;
  logic           x_end;
  logic           y_end;

  assign x_end = (cx_q == w_max_i);
  assign y_end = (cy_q == h_max_i);

  // Next coordinate: cx runs fastest, wraps to the next row at the right edge
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = y_end ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Coordinate registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = x_end && y_end;

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite/rect/clear blitter streaming one clipped pixel per cycle to vga_adapter (optional SPRITE_BLITTER_TRANSPARENT_EN)
module sprite_blitter
  import blitter_pkg::*;
#(
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOUR_W   = COLOUR_W_DEF,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int SPR_W_LOG2 = 4,
  parameter int SPR_H_LOG2 = 4,
  parameter int ID_W       = 2,
  parameter int TRANSP_KEY = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  start_i,
  input  logic [1:0]                            mode_i,
  input  logic [X_W-1:0]                        pos_x_i,
  input  logic [Y_W-1:0]                        pos_y_i,
  input  logic [ID_W-1:0]                       sprite_id_i,
  input  logic [COLOUR_W-1:0]                   fill_colour_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [ID_W+SPR_H_LOG2+SPR_W_LOG2-1:0] rom_addr_o,
  input  logic [COLOUR_W-1:0]                   rom_data_i,
  output logic [X_W-1:0]                        vga_x_o,
  output logic [Y_W-1:0]                        vga_y_o,
  output logic [COLOUR_W-1:0]                   vga_colour_o,
  output logic                                  vga_plot_o
);

  // Scan extents expressed as last index, plus clip limits one bit wider than the coordinates
  localparam logic [X_W-1:0]      SPR_W_MAX = X_W'((1 << SPR_W_LOG2) - 1);
  localparam logic [Y_W-1:0]      SPR_H_MAX = Y_W'((1 << SPR_H_LOG2) - 1);
  localparam logic [X_W-1:0]      SCR_W_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]      SCR_H_MAX = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]        SCR_W_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]        SCR_H_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [COLOUR_W-1:0] KEY       = COLOUR_W'(TRANSP_KEY);

`ifdef SPRITE_BLITTER_TRANSPARENT_EN
  localparam logic TRANSP_EN = 1'b1;
`else
  localparam logic TRANSP_EN = 1'b0;
`endif

  // Command sequencer and latched command
  state_e              state_q;
  logic                flush_q;
  logic [1:0]          mode_q;
  logic [X_W-1:0]      pos_x_q;
  logic [Y_W-1:0]      pos_y_q;
  logic [ID_W-1:0]     id_q;
  logic [COLOUR_W-1:0] fill_q;
  logic                busy_q;
  logic                done_q;

  // Scan counter interface
  logic                accept;
  logic                running;
  logic                clear_mode;
  logic                sprite_mode;
  logic [X_W-1:0]      w_max;
  logic [Y_W-1:0]      h_max;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  logic                scan_last;

  // S0: screen coordinate and clip decision for the issued (cx,cy)
  logic [X_W:0]        px_full;
  logic [Y_W:0]        py_full;
  logic                in_bounds;

  // Stage registers: s0 aligns with the ROM read, s1 holds the chosen colour
  logic                v0_q;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic                spr0_q;
  logic                transp;
  logic                v1_q;
  logic [X_W-1:0]      x1_q;
  logic [Y_W-1:0]      y1_q;
  logic [COLOUR_W-1:0] c1_q;

  // S2: outputs to vga_adapter
  logic                plot_q;
  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic [COLOUR_W-1:0] vga_c_q;

  assign accept      = (state_q == IDLE) && start_i;
  assign running     = (state_q == RUN);
  assign clear_mode  = mode_is_clear(mode_q);
  assign sprite_mode = mode_is_sprite(mode_q);
  assign w_max       = clear_mode ? SCR_W_MAX : SPR_W_MAX;
  assign h_max       = clear_mode ? SCR_H_MAX : SPR_H_MAX;

  blit_scan_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_scan (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (accept),
    .en_i    (running),
    .w_max_i (w_max),
    .h_max_i (h_max),
    .cx_o    (cx),
    .cy_o    (cy),
    .last_o  (scan_last)
  );

  // Command FSM: latch on accept, scan, drain two pipeline stages, pulse done
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      mode_q  <= MODE_SPRITE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      id_q    <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            pos_x_q <= pos_x_i;
            pos_y_q <= pos_y_i;
            id_q    <= sprite_id_i;
            fill_q  <= fill_colour_i;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (scan_last) begin
            flush_q <= 1'b0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Clear ignores the position; sprite/fill add the offset at one extra bit so overflow clips
  always_comb begin
    px_full = '0;
    py_full = '0;
    if (clear_mode) begin
      px_full = {1'b0, cx};
      py_full = {1'b0, cy};
    end else begin
      px_full = {1'b0, pos_x_q} + {1'b0, cx};
      py_full = {1'b0, pos_y_q} + {1'b0, cy};
    end
    in_bounds = (px_full < SCR_W_LIM) && (py_full < SCR_H_LIM);
  end

  assign rom_addr_o = {id_q, cy[SPR_H_LOG2-1:0], cx[SPR_W_LOG2-1:0]};

  // S0 register: travels alongside the synchronous ROM read
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v0_q   <= 1'b0;
      x0_q   <= '0;
      y0_q   <= '0;
      spr0_q <= 1'b0;
    end else begin
      v0_q   <= running && in_bounds;
      x0_q   <= px_full[X_W-1:0];
      y0_q   <= py_full[Y_W-1:0];
      spr0_q <= sprite_mode;
    end
  end

  // Transparent sprite texels are dropped like clipped ones so timing is unchanged
  assign transp = TRANSP_EN && spr0_q && (rom_data_i == KEY);

  // S1 register: pick ROM data or the fill colour
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      c1_q <= '0;
    end else begin
      v1_q <= v0_q && !transp;
      x1_q <= x0_q;
      y1_q <= y0_q;
      c1_q <= spr0_q ? rom_data_i : fill_q;
    end
  end

  // S2 register: vga outputs hold their last value whenever nothing is plotted
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      plot_q  <= 1'b0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
    end else begin
      plot_q <= v1_q;
      if (v1_q) begin
        vga_x_q <= x1_q;
        vga_y_q <= y1_q;
        vga_c_q <= c1_q;
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign vga_plot_o   = plot_q;
  assign vga_x_o      = vga_x_q;
  assign vga_y_o      = vga_y_q;
  assign vga_colour_o = vga_c_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter against a raster-order pixel model
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [8:0]  pos_x;
  logic [7:0]  pos_y;
  logic [1:0]  sprite_id;
  logic [14:0] fill_colour;
  logic        busy;
  logic        done;
  logic [9:0]  rom_addr;
  logic [14:0] rom_data;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [14:0] vga_colour;
  logic        vga_plot;

  logic [14:0] rom [0:1023];

  int n_checks = 0;
  int n_pass   = 0;

  // Expected held outputs, tracked from the model only
  logic [8:0]  last_x = '0;
  logic [7:0]  last_y = '0;
  logic [14:0] last_c = '0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  sprite_blitter dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .mode_i        (mode),
    .pos_x_i       (pos_x),
    .pos_y_i       (pos_y),
    .sprite_id_i   (sprite_id),
    .fill_colour_i (fill_colour),
    .busy_o        (busy),
    .done_o        (done),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .vga_x_o       (vga_x),
    .vga_y_o       (vga_y),
    .vga_colour_o  (vga_colour),
    .vga_plot_o    (vga_plot)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pixel k of a command in raster order: where it lands, its colour, and whether it is drawn
  function automatic void ref_pixel(input int m, input int x0, input int y0, input int id,
                                    input int col, input int k,
                                    output bit plot, output int x, output int y, output int c);
    int w;
    int cx;
    int cy;
    w  = (m >= 2) ? 320 : 16;
    cx = k % w;
    cy = k / w;
    if (m >= 2) begin
      x = cx;
      y = cy;
      c = col;
      plot = 1'b1;
    end else begin
      x = x0 + cx;
      y = y0 + cy;
      plot = (x < 320) && (y < 240);
      c = (m == 0) ? int'(rom[id * 256 + cy * 16 + cx]) : col;
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
      if (m == 0 && c == 0) plot = 1'b0;
`endif
    end
  endfunction

  // Issue one command at the current negedge and follow it cycle by cycle.
  // hold: cycles start stays high; repulse: sample index to re-pulse start; abort: pixel index at which reset hits
  task automatic run_cmd(input int m, input int x0, input int y0, input int id, input int col,
                         input int hold, input int repulse, input int abort, input string name);
    int  n;
    int  jmax;
    int  perr;
    int  first_bad;
    int  berr;
    int  dcount;
    int  dj;
    int  plots;
    int  eplots;
    int  qerr;
    bit  ep;
    int  ex;
    int  ey;
    int  ec;
    n = (m >= 2) ? 76800 : 256;
    jmax = (abort >= 0) ? 3 + abort : n + 3;
    perr = 0; first_bad = -1; berr = 0; dcount = 0; dj = -1; plots = 0; eplots = 0;
    start = 1'b1;
    mode = m[1:0];
    pos_x = x0[8:0];
    pos_y = y0[7:0];
    sprite_id = id[1:0];
    fill_colour = col[14:0];
    for (int j = 0; j <= jmax; j++) begin
      @(negedge clk);
      ep = 1'b0;
      if (j >= 3 && j - 3 < n) ref_pixel(m, x0, y0, id, col, j - 3, ep, ex, ey, ec);
      if (ep) begin
        last_x = ex[8:0];
        last_y = ey[7:0];
        last_c = ec[14:0];
        eplots++;
      end
      if (vga_plot !== ep || vga_x !== last_x || vga_y !== last_y || vga_colour !== last_c) begin
        perr++;
        if (first_bad < 0) first_bad = j;
      end
      if (vga_plot === 1'b1) plots++;
      if (done === 1'b1) begin
        dcount++;
        dj = j;
      end
      if (busy !== (j <= n + 2)) berr++;
      start = (j + 1 < hold) || (j == repulse);
      if (j == repulse) begin
        mode = 2'd2;
        pos_x = 9'd0;
        pos_y = 8'd0;
        fill_colour = 15'h1234;
      end
    end
    check($sformatf("%s_pixels(first_bad_cycle=%0d)", name, first_bad), perr, 0);
    check({name, "_plot_count"}, plots, eplots);
    check({name, "_busy"}, berr, 0);
    check({name, "_done_count"}, dcount, (abort >= 0) ? 0 : 1);
    if (abort < 0) check({name, "_done_cycle"}, dj, n + 3);
    if (abort >= 0) begin
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check({name, "_rst_plot"}, vga_plot, 0);
      check({name, "_rst_busy"}, busy, 0);
      check({name, "_rst_done"}, done, 0);
      check({name, "_rst_x"}, vga_x, 0);
      reset = 1'b0;
      last_x = '0;
      last_y = '0;
      last_c = '0;
      qerr = 0;
      repeat (4) begin
        @(negedge clk);
        if (vga_plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) qerr++;
      end
      check({name, "_quiet_after_reset"}, qerr, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = 15'(a);
    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    pos_x = '0;
    pos_y = '0;
    sprite_id = '0;
    fill_colour = '0;
    repeat (3) @(negedge clk);
    check("reset_plot", vga_plot, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_x", vga_x, 0);
    check("reset_y", vga_y, 0);
    check("reset_colour", vga_colour, 0);
    check("reset_rom_addr", rom_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(0, 10, 20, 1, 0, 1, -1, -1, "t1_sprite");
    run_cmd(1, 312, 232, 0, 15'h7C00, 1, -1, -1, "t2_fill_clip");
    run_cmd(0, 100, 50, 2, 0, 6, 120, -1, "t4_start_held");
    run_cmd(0, 30, 40, 3, 0, 1, -1, 100, "t5_reset_mid");
    run_cmd(0, 30, 40, 3, 0, 1, -1, -1, "t5_after_reset");

    for (int a = 0; a < 1024; a++)
      rom[a] = ($urandom_range(0, 1) == 0) ? 15'd0 : 15'($urandom_range(1, 32767));

    run_cmd(0, 10, 20, 1, 0, 1, -1, -1, "t6_sprite_keyed");
    run_cmd(0, 304, 224, 0, 0, 1, -1, -1, "edge_fits");
    run_cmd(1, 320, 0, 0, 15'h03E0, 1, -1, -1, "edge_all_clipped");
    run_cmd(0, 511, 255, 2, 0, 1, -1, -1, "edge_max_pos");
    for (int i = 0; i < 6; i++) begin
      run_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 340)), int'($urandom_range(0, 250)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 32767)), 1, -1, -1,
              $sformatf("rand%0d", i));
    end
    run_cmd(3, 50, 60, 0, 15'h001F, 1, -1, 500, "reserved_mode");
    run_cmd(2, 77, 88, 0, 0, 1, -1, -1, "t3_clear");

    @(negedge clk);
    check("final_idle_plot", vga_plot, 0);
    check("final_idle_done", done, 0);
    check("final_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
